// File: rtl/reg_pkg.sv
// Shared register-file types and named indices for the RV32I datapath.
package reg_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_A0   = 10;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_file.sv
// 32-entry register file: two combinational read ports, one synchronous write port, x0 fixed at zero.
// Optional write-through forwarding on the read ports under `REG_FILE_WRITE_BYPASS_EN.
module reg_file
  import reg_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = REG_ADDR_W,
  parameter int unsigned DATA_WIDTH = REG_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] AD1,
  input  logic [ADDR_WIDTH-1:0] AD2,
  input  logic [ADDR_WIDTH-1:0] AD3,
  input  logic                  WE3,
  input  logic [DATA_WIDTH-1:0] WD3,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2,
  output logic [DATA_WIDTH-1:0] a0
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = ADDR_WIDTH'(REG_ZERO);
  localparam logic [ADDR_WIDTH-1:0] ADDR_A0   = ADDR_WIDTH'(REG_A0);

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  wr_en_c;

  // WE3 gates the address compare, so an undriven AD3 never causes a write.
  assign wr_en_c = WE3 && (AD3 != ADDR_ZERO);

  // Storage and the a0 mirror; reset wins over a same-edge write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      a0 <= '0;
    end else begin
      if (wr_en_c) begin
        regs[AD3] <= WD3;
      end
      a0 <= (WE3 && (AD3 == ADDR_A0)) ? WD3 : regs[ADDR_A0];
    end
  end

`ifdef REG_FILE_WRITE_BYPASS_EN
  logic byp1_c;
  logic byp2_c;

  // Forward the in-flight write, but never while reset is holding the array.
  assign byp1_c = !rst && wr_en_c && (AD3 == AD1);
  assign byp2_c = !rst && wr_en_c && (AD3 == AD2);

  always_comb begin
    RD1 = '0;
    RD2 = '0;
    if (AD1 != ADDR_ZERO) begin
      RD1 = byp1_c ? WD3 : regs[AD1];
    end
    if (AD2 != ADDR_ZERO) begin
      RD2 = byp2_c ? WD3 : regs[AD2];
    end
  end
`else
  always_comb begin
    RD1 = '0;
    RD2 = '0;
    if (AD1 != ADDR_ZERO) begin
      RD1 = regs[AD1];
    end
    if (AD2 != ADDR_ZERO) begin
      RD2 = regs[AD2];
    end
  end
`endif

endmodule

// File: tb/tb_reg_file.sv
// Directed vector bench for reg_file; expectations follow `REG_FILE_WRITE_BYPASS_EN when defined.
module tb_reg_file;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

`ifdef REG_FILE_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic          rst;
    logic          we;
    logic [AW-1:0] ad3;
    logic [DW-1:0] wd3;
    logic [AW-1:0] ad1;
    logic [AW-1:0] ad2;
    logic [DW-1:0] exp_rd1;
    logic [DW-1:0] exp_rd2;
    logic [DW-1:0] exp_a0;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] ad1, ad2, ad3;
  logic          we3;
  logic [DW-1:0] wd3;
  logic [DW-1:0] rd1, rd2, a0;

  int tests = 0;
  int fails = 0;

  reg_file dut (
    .clk (clk),
    .rst (rst),
    .AD1 (ad1),
    .AD2 (ad2),
    .AD3 (ad3),
    .WE3 (we3),
    .WD3 (wd3),
    .RD1 (rd1),
    .RD2 (rd2),
    .a0  (a0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] sweep_val(input int i);
    logic [DW-1:0] v;
    v = DW'(i) * 32'h0101_0101;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    // Expected read values are the pre-edge values; a0 is checked after the edge.
    vecs.push_back('{1'b0, 1'b1, 5'd5,  32'hDEAD_BEEF, 5'd0,  5'd0,  32'h0, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 5'd0,  32'h0,         5'd5,  5'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0});
    vecs.push_back('{1'b0, 1'b0, 5'd0,  32'h0,         5'd5,  5'd0,  32'h0, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 5'd5,  32'hDEAD_BEEF, 5'd0,  5'd0,  32'h0, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 1'b1, 5'd7,  32'h0000_1234, 5'd5,  5'd7,  32'hDEAD_BEEF, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 1'b0, 5'd0,  32'h0,         5'd7,  5'd5,  32'h0, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 5'd3,  32'h0000_00A5, 5'd3,  5'd0,  BYP ? 32'hA5 : 32'h0, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 1'b0, 5'd0,  32'h0,         5'd3,  5'd3,  32'hA5, 32'hA5, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  32'h0, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 1'b0, 5'd0,  32'h0,         5'd0,  5'd3,  32'h0, 32'hA5, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 5'd10, 32'h0000_0064, 5'd10, 5'd0,  BYP ? 32'h64 : 32'h0, 32'h0, 32'h64});
    vecs.push_back('{1'b0, 1'b1, 5'd11, 32'h0000_0077, 5'd10, 5'd11, 32'h64, BYP ? 32'h77 : 32'h0, 32'h64});
    vecs.push_back('{1'b0, 1'b1, 5'd4,  32'h0000_0011, 5'd4,  5'd0,  BYP ? 32'h11 : 32'h0, 32'h0, 32'h64});
    vecs.push_back('{1'b0, 1'b1, 5'd4,  32'h0000_0022, 5'd4,  5'd4,  BYP ? 32'h22 : 32'h11, BYP ? 32'h22 : 32'h11, 32'h64});
    vecs.push_back('{1'b0, 1'b0, 5'd0,  32'h0,         5'd4,  5'd11, 32'h22, 32'h77, 32'h64});
    vecs.push_back('{1'b0, 1'b1, 5'd0,  32'h0000_0022, 5'd0,  5'd0,  32'h0, 32'h0, 32'h64});
    vecs.push_back('{1'b0, 1'b0, 5'bx,  32'hFFFF_FFFF, 5'd4,  5'd10, 32'h22, 32'h64, 32'h64});
    vecs.push_back('{1'b0, 1'b0, 5'd0,  32'h0,         5'd4,  5'd10, 32'h22, 32'h64, 32'h64});

    rst = 1'b1; we3 = 1'b0; ad1 = '0; ad2 = '0; ad3 = '0; wd3 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a0", a0, 32'h0);
    chk("reset_rd1_x5", rd1, 32'h0);

    foreach (vecs[k]) begin
      @(negedge clk);
      rst = vecs[k].rst; we3 = vecs[k].we; ad3 = vecs[k].ad3; wd3 = vecs[k].wd3;
      ad1 = vecs[k].ad1; ad2 = vecs[k].ad2;
      #1;
      chk($sformatf("vec%0d_rd1", k), rd1, vecs[k].exp_rd1);
      chk($sformatf("vec%0d_rd2", k), rd2, vecs[k].exp_rd2);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_a0", k), a0, vecs[k].exp_a0);
    end

    // Sweep: fill x1..x31 then read mirrored pairs.
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      rst = 1'b0; we3 = 1'b1; ad3 = AW'(i); wd3 = sweep_val(i);
    end
    @(negedge clk);
    we3 = 1'b0; ad3 = '0; wd3 = '0;
    chk("sweep_a0", a0, 32'h0A0A_0A0A);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      ad1 = AW'(i); ad2 = AW'(31 - i);
      #1;
      chk($sformatf("sweep_rd1_x%0d", i), rd1, (i == 0) ? 32'h0 : sweep_val(i));
      chk($sformatf("sweep_rd2_x%0d", 31 - i), rd2, (i == 31) ? 32'h0 : sweep_val(31 - i));
    end

    // Reset after the sweep clears every register and a0.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("post_sweep_reset_a0", a0, 32'h0);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      ad1 = AW'(i); ad2 = AW'(31 - i);
      #1;
      chk($sformatf("cleared_rd1_x%0d", i), rd1, 32'h0);
      chk($sformatf("cleared_rd2_x%0d", 31 - i), rd2, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- 32-entry architectural register file for the single-cycle RV32I datapath.
- It supplies the ALU operand buses (RD1 feeds ALUop1, RD2 feeds the operand-2 mux) and accepts write-back of the ALU result or load data.
- Two asynchronous read ports, one synchronous write port, x0 hardwired to zero.
- Register a0 (x10) is exposed for the test bench and top-level output.

Parameters:
- ADDR_WIDTH, 5, register index width; depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 32, register and bus width; must match the ALU WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- AD1  input  ADDR_WIDTH  read address, port 1 (rs1).
- AD2  input  ADDR_WIDTH  read address, port 2 (rs2).
- AD3  input  ADDR_WIDTH  write address (rd).
- WE3  input  1  write enable.
- WD3  input  DATA_WIDTH  write data (ALU result or load data).
- RD1  output  DATA_WIDTH  read data, port 1.
- RD2  output  DATA_WIDTH  read data, port 2.
- a0  output  DATA_WIDTH  registered copy of x10.

Behaviour:
- One clock. Reset is synchronous and active-high: clk and rst; rst is sampled only on the rising edge of clk.
- Storage: 2**ADDR_WIDTH words of DATA_WIDTH bits.
- Reset: on a rising edge with rst=1, all registers become 0 and a0 becomes 0. Reset has priority over a write in the same cycle. RD1/RD2 read 0 for every address from the cycle after reset.
- Reset mid-operation: a write pending on the reset edge is discarded; there is no partial state.
- Write:
  - On a rising edge with rst=0, WE3=1 and AD3!=0, reg[AD3] <= WD3. Latency is 1 cycle.
  - WE3=0: no state change.
  - AD3=0 with WE3=1: the write is silently dropped; x0 stays 0.
- Read:
  - Combinational. RD1 = (AD1==0) ? 0 : reg[AD1]; likewise RD2 with AD2.
  - Zero latency, so a single-cycle instruction gets its operands in the same cycle.
  - AD1==AD2 is legal; both ports return the same value.
- Read/write collision, same cycle, same nonzero address: without the optional feature, RD returns the old value. The new value is visible from the next cycle.
- a0 output:
  - Registered. On each non-reset edge, a0 <= next value of x10: WD3 if WE3=1 and AD3=10, else the current x10.
  - So a0 equals x10 at all times after the edge, with no extra cycle of lag.
- Unknowns: X on AD3 while WE3=0 has no effect. The implementation must not write on X address when WE3=0.

Optional Feature:
- Macro: REG_FILE_WRITE_BYPASS_EN.
- Defined: if WE3=1, AD3!=0 and AD3==ADn, then RDn = WD3 in the same cycle (write-through forwarding). Used when the write-back stage is pipelined.
  - Forwarding is still suppressed for x0.
  - Forwarding is suppressed while rst=1, so RDn shows the stored value.
- Undefined: pure array read as described above, with no forwarding logic.

Decomposition:
- Shared package reg_pkg holds:
  - REG_ADDR_W = 5 and REG_DATA_W = 32.
  - Named indices REG_ZERO = 0 and REG_A0 = 10.
  - typedef reg_addr_t (logic [4:0]) and reg_data_t (logic [31:0]).
  - The ALU and the control unit import the same types.
- No sub-module is natural; the write decode and read muxes stay inline.

Test Plan:
- Reset: write x5=0xDEADBEEF, assert rst for 1 edge. Then read AD1=5 -> RD1=0 and a0=0. Also assert rst and WE3 on the same edge (AD3=7, WD3=0x1234) -> x7=0.
- Basic write/read: WE3=1, AD3=3, WD3=0x0000_00A5, one edge. Then AD1=3, AD2=3 -> RD1=RD2=0xA5. Before the edge, RD1=0.
- x0 protection: WE3=1, AD3=0, WD3=0xFFFF_FFFF -> RD1 with AD1=0 stays 0 after the edge.
- a0 tracking: WE3=1, AD3=10, WD3=0x0000_0064 -> a0=0x64 after that edge. A write to x11 -> a0 unchanged.
- Collision: x4=0x11. Same cycle: WE3=1, AD3=4, WD3=0x22, AD1=4.
  - Without the macro: RD1=0x11 before the edge, 0x22 after.
  - With REG_FILE_WRITE_BYPASS_EN: RD1=0x22 immediately.
  - Repeat with AD3=0 -> RD1=0 in both builds.
- Sweep: write each x1..x31 with value (i*0x01010101), then read all pairs (i, 31-i) -> exact values. x0 reads 0.
